argmax_classifier: RTL
======================

Name: argmax_classifier

Overview:
- Downstream consumer of the softmax stage in the Classification-CNN pipeline.
- Accepts one frame of NUM_CLASSES probability scores, one score per accepted beat, over a valid/ready stream.
- Tracks the running maximum and its index, then presents the winning class id and its score on a held output handshake.
- Flags frames whose length does not match NUM_CLASSES.

Parameters:
- DATA_W, 8, width of each probability score (unsigned).
- NUM_CLASSES, 1024, expected scores per frame; legal range 2..65536.
- IDX_W, $clog2(NUM_CLASSES), width of class index and beat counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  score beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  DATA_W  unsigned score.
- in_last  in  1  final beat of frame.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_class  out  IDX_W  index of maximum score.
- out_score  out  DATA_W  maximum score value.
- out_len_err  out  1  frame length mismatch for this result.

Behaviour:
- One clock, clk. Reset rst is asynchronous and active-high. All state clears immediately on rst assertion.
- Reset values: out_valid=0, out_class=0, out_score=0, out_len_err=0, beat counter=0, state=ACCUM.
- in_ready is combinational from state: 1 in ACCUM, 0 in HOLD, 0 while rst is high.
- A beat is accepted when in_valid && in_ready.
- States:
  - ACCUM: on each accepted beat with counter==0, load max=in_data and idx=0 unconditionally.
  - ACCUM: on each later accepted beat, if in_data > max (strictly, unsigned), load max=in_data and idx=counter.
  - Ties keep the lower index.
  - Counter increments on every accepted beat.
  - Frame closes on the accepted beat where in_last=1 OR counter==NUM_CLASSES-1, whichever comes first. The closing beat itself participates in the compare.
  - On close: register out_class/out_score from the updated max, set out_len_err = (in_last XOR counter==NUM_CLASSES-1), set out_valid=1, go to HOLD, clear counter.
  - HOLD: out_valid=1; out_class, out_score and out_len_err are held stable.
  - HOLD: on out_valid && out_ready, drop out_valid next cycle and return to ACCUM. New beats are accepted from the cycle after the handshake.
- Latency: out_valid rises on the cycle after the closing beat is accepted. Throughput is one frame per NUM_CLASSES+1 cycles minimum (one bubble cycle for the HOLD handshake).
- Short frame (in_last before NUM_CLASSES beats): result is the max over the received beats, out_len_err=1.
- Long frame (no in_last by beat NUM_CLASSES): frame is force-closed with out_len_err=1. Subsequent beats, including a late in_last, form the next frame.
- Single-beat frame (in_last on first beat): out_class=0, out_score=in_data, out_len_err=1.
- in_data is ignored when not accepted. out_ready is ignored outside HOLD.
- rst asserted mid-frame or mid-HOLD: the partial frame and any pending result are discarded; nothing is emitted.

Optional Feature:
- Macro ARGMAX_TOP2_EN.
- Defined: adds ports out_class2 (out, IDX_W) and out_score2 (out, DATA_W), both reset to 0 and held in HOLD like the primary outputs. These carry the runner-up:
  - On a new strict max, the old max shifts to second.
  - Otherwise, if in_data > second (or second is not yet loaded), second is replaced.
  - Ties keep the lower index.
  - On a single-beat frame, second reports class 0, score 0.
- Undefined: ports and logic are absent; primary behaviour is identical.

Test Plan:
- NUM_CLASSES=4, beats 10,200,50,30 with in_last on the 4th -> out_valid one cycle after the 4th beat; out_class=1, out_score=200, out_len_err=0.
- Ties: beats 90,90,90,90 + last -> out_class=0, out_score=90. Beats 5,255,255,1 -> out_class=1, out_score=255.
- Backpressure: result out_class=3 held with out_ready=0 for 5 cycles -> in_ready=0 and outputs stable throughout; out_ready=1 -> in_ready=1 the next cycle; next frame 7,0,0,0 gives out_class=0.
- Length errors: beats 3,9 with last on the 2nd -> out_class=1, out_score=9, out_len_err=1. Six beats with no last -> force-close after 4th beat with out_len_err=1; remaining 2 beats start the next frame.
- Reset: rst asserted after 2 beats of a frame -> out_valid stays 0. Next full frame 1,2,3,4 + last -> out_class=3, out_score=4, out_len_err=0.
- ARGMAX_TOP2_EN: beats 10,200,50,30 -> out_class2=2, out_score2=50. Beats 200,10,250,5 -> out_class=2, out_class2=0, out_score2=200.

Source files
------------

// File: rtl/argmax_classifier.sv
`default_nettype none
// ============================================================================
// Module   : argmax_classifier
// Brief    : Streams one frame of scores and reports the index and value of the
//            maximum, flagging length mismatches. Define ARGMAX_TOP2_EN to also
//            report the runner-up class and score.
// Revision : 1.0
// ============================================================================
module argmax_classifier #(
    parameter int DATA_W      = 8,
    parameter int NUM_CLASSES = 1024,
    parameter int IDX_W       = $clog2(NUM_CLASSES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  out_class,
    output logic [DATA_W-1:0] out_score,
`ifdef ARGMAX_TOP2_EN
    output logic [IDX_W-1:0]  out_class2,
    output logic [DATA_W-1:0] out_score2,
`endif
    output logic              out_len_err
);

    localparam logic [IDX_W-1:0] c_LAST = IDX_W'(NUM_CLASSES - 1);
    localparam logic [IDX_W-1:0] c_ONE  = IDX_W'(1);

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t            r_state;
    logic [IDX_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_max;
    logic [IDX_W-1:0]  r_idx;
    logic              r_out_valid;
    logic [IDX_W-1:0]  r_out_class;
    logic [DATA_W-1:0] r_out_score;
    logic              r_out_len_err;

    logic              w_accept;
    logic              w_first;
    logic              w_gt;
    logic              w_at_end;
    logic              w_close;
    logic [DATA_W-1:0] w_max_nxt;
    logic [IDX_W-1:0]  w_idx_nxt;

    assign in_ready = (r_state == ACCUM) && !rst;
    assign w_accept = in_valid && in_ready;
    assign w_first  = (r_cnt == '0);
    assign w_gt     = (in_data > r_max);
    assign w_at_end = (r_cnt == c_LAST);
    assign w_close  = w_accept && (in_last || w_at_end);

    // The first beat of a frame loads unconditionally; strict compare keeps the lower index on ties.
    assign w_max_nxt = (w_first || w_gt) ? in_data : r_max;
    assign w_idx_nxt = w_first ? '0 : (w_gt ? r_cnt : r_idx);

`ifdef ARGMAX_TOP2_EN
    logic [DATA_W-1:0] r_max2;
    logic [IDX_W-1:0]  r_idx2;
    logic              r_sec_vld;
    logic [IDX_W-1:0]  r_out_class2;
    logic [DATA_W-1:0] r_out_score2;
    logic [DATA_W-1:0] w_max2_nxt;
    logic [IDX_W-1:0]  w_idx2_nxt;
    logic              w_sec_vld_nxt;

    always_comb begin
        w_max2_nxt    = r_max2;
        w_idx2_nxt    = r_idx2;
        w_sec_vld_nxt = r_sec_vld;
        if (w_first) begin
            w_max2_nxt    = '0;
            w_idx2_nxt    = '0;
            w_sec_vld_nxt = 1'b0;
        end else if (w_gt) begin
            w_max2_nxt    = r_max;
            w_idx2_nxt    = r_idx;
            w_sec_vld_nxt = 1'b1;
        end else if (!r_sec_vld || (in_data > r_max2)) begin
            w_max2_nxt    = in_data;
            w_idx2_nxt    = r_cnt;
            w_sec_vld_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_max2       <= '0;
            r_idx2       <= '0;
            r_sec_vld    <= 1'b0;
            r_out_class2 <= '0;
            r_out_score2 <= '0;
        end else if (w_accept) begin
            r_max2    <= w_max2_nxt;
            r_idx2    <= w_idx2_nxt;
            r_sec_vld <= w_sec_vld_nxt;
            if (w_close) begin
                r_out_class2 <= w_idx2_nxt;
                r_out_score2 <= w_max2_nxt;
            end
        end
    end

    assign out_class2 = r_out_class2;
    assign out_score2 = r_out_score2;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ACCUM;
            r_cnt         <= '0;
            r_max         <= '0;
            r_idx         <= '0;
            r_out_valid   <= 1'b0;
            r_out_class   <= '0;
            r_out_score   <= '0;
            r_out_len_err <= 1'b0;
        end else begin
            case (r_state)
                ACCUM: begin
                    if (w_accept) begin
                        r_max <= w_max_nxt;
                        r_idx <= w_idx_nxt;
                        if (w_close) begin
                            r_cnt         <= '0;
                            r_out_class   <= w_idx_nxt;
                            r_out_score   <= w_max_nxt;
                            r_out_len_err <= in_last ^ w_at_end;
                            r_out_valid   <= 1'b1;
                            r_state       <= HOLD;
                        end else begin
                            r_cnt <= r_cnt + c_ONE;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ACCUM;
                    end
                end
                default: r_state <= ACCUM;
            endcase
        end
    end

    assign out_valid   = r_out_valid;
    assign out_class   = r_out_class;
    assign out_score   = r_out_score;
    assign out_len_err = r_out_len_err;

endmodule
`default_nettype wire
